// File: rtl/fib_seq_ctrl_if.sv
// Handshake and register-file port bundle for the Fibonacci sequencer.
// slave = sequencer side, master = top-level / datapath side.
interface fib_seq_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] f0;
    logic [DATA_W-1:0] f1;
    logic              alu_cout;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wa;
    logic              we;
    logic              wd_sel;
    logic [DATA_W-1:0] init_data;
    logic              busy;
    logic              done;
    logic              ovf;

    modport slave (
        input  start, len, f0, f1, alu_cout,
        output ra1, ra2, wa, we, wd_sel, init_data,
        output busy, done, ovf
    );

    modport master (
        output start, len, f0, f1, alu_cout,
        input  ra1, ra2, wa, we, wd_sel, init_data,
        input  busy, done, ovf
    );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Sequencer filling register-file entries 0..L-1 with a Fibonacci series.
// All outputs are registered alongside the state they belong to.
module fib_seq_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fib_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, S0, S1, RD, WR, DONE
    } state_t;

    localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] TWO    = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [ADDR_W:0] MAXLEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    logic [ADDR_W:0]   r_k;
    logic [ADDR_W:0]   r_len;
    logic [DATA_W-1:0] r_f1;
    logic [ADDR_W-1:0] r_ra1;
    logic [ADDR_W-1:0] r_ra2;
    logic [ADDR_W-1:0] r_wa;
    logic              r_we;
    logic              r_wd_sel;
    logic [DATA_W-1:0] r_init;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;

    logic [ADDR_W:0]   w_len_clamp;
    logic [ADDR_W:0]   w_k_m1;
    logic [ADDR_W:0]   w_k_p1;
    logic              w_last;

    always_comb begin
        w_len_clamp = bus.len;
        if (bus.len < TWO)
            w_len_clamp = TWO;
        else if (bus.len > MAXLEN)
            w_len_clamp = MAXLEN;
    end

    // k is one bit wider than an address so a full-depth run ends cleanly
    assign w_k_m1 = r_k - ONE;
    assign w_k_p1 = r_k + ONE;
    assign w_last = (r_k == r_len - ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_len    <= '0;
            r_f1     <= '0;
            r_ra1    <= '0;
            r_ra2    <= '0;
            r_wa     <= '0;
            r_we     <= 1'b0;
            r_wd_sel <= 1'b0;
            r_init   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state  <= S0;
                        r_len    <= w_len_clamp;
                        r_f1     <= bus.f1;
                        r_ovf    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_we     <= 1'b1;
                        r_wd_sel <= 1'b0;
                        r_wa     <= '0;
                        r_init   <= bus.f0;
                    end
                end
                S0: begin
                    r_state <= S1;
                    r_wa    <= ONE[ADDR_W-1:0];
                    r_init  <= r_f1;
                end
                S1: begin
                    r_k    <= TWO;
                    r_init <= '0;
                    if (r_len == TWO) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_we    <= 1'b0;
                        r_wa    <= '0;
                    end else begin
                        r_state  <= RD;
                        r_we     <= 1'b0;
                        r_wd_sel <= 1'b1;
                        r_ra1    <= '0;
                        r_ra2    <= ONE[ADDR_W-1:0];
                        r_wa     <= TWO[ADDR_W-1:0];
                    end
                end
                RD: begin
                    r_state <= WR;
                    r_we    <= 1'b1;
                end
                WR: begin
                    if (bus.alu_cout)
                        r_ovf <= 1'b1;
                    r_we <= 1'b0;
                    if (w_last) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_wd_sel <= 1'b0;
                        r_ra1    <= '0;
                        r_ra2    <= '0;
                        r_wa     <= '0;
                    end else begin
                        r_state <= RD;
                        r_k     <= w_k_p1;
                        r_ra1   <= w_k_m1[ADDR_W-1:0];
                        r_ra2   <= r_k[ADDR_W-1:0];
                        r_wa    <= w_k_p1[ADDR_W-1:0];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ra1       = r_ra1;
    assign bus.ra2       = r_ra2;
    assign bus.wa        = r_wa;
    assign bus.we        = r_we;
    assign bus.wd_sel    = r_wd_sel;
    assign bus.init_data = r_init;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench: sequencer driving a behavioural register file and adder.
// Expected series values and cycle counts are hand-computed.
module tb_fib_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   total_w = 0;
    logic [4:0] last_wa = '0;

    fib_seq_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    fib_seq_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rf [32];
    logic [8:0] sum;
    logic [7:0] wd;

    assign sum          = {1'b0, rf[bus.ra1]} + {1'b0, rf[bus.ra2]};
    assign bus.alu_cout = sum[8];
    assign wd           = bus.wd_sel ? sum[7:0] : bus.init_data;

    always @(posedge clk) begin
        if (bus.we) begin
            rf[bus.wa] <= wd;
            total_w    <= total_w + 1;
            last_wa    <= bus.wa;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept a run, then count cycles (1 = first cycle after acceptance)
    task automatic run(input logic [5:0] l, input logic [7:0] a,
                       input logic [7:0] b, input bit poke,
                       output int dcyc, output int bcnt, output int nw);
        int  w0;
        bit  poked;
        for (int i = 0; i < 200 && (bus.busy || bus.done); i++)
            tick();
        bus.len   = l;
        bus.f0    = a;
        bus.f1    = b;
        bus.start = 1'b1;
        w0        = total_w;
        tick();
        bus.start = 1'b0;
        dcyc  = 0;
        bcnt  = 0;
        poked = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.busy)
                bcnt++;
            if (bus.done) begin
                dcyc = c;
                break;
            end
            bus.start = 1'b0;
            if (poke && !poked && bus.we && bus.wd_sel) begin
                poked     = 1'b1;
                bus.start = 1'b1;
                bus.len   = 6'd3;
            end
            tick();
        end
        bus.start = 1'b0;
        nw = total_w - w0;
    endtask

    int dc, bc, nw, w0;
    logic [7:0] exp8 [8];

    initial begin
        for (int i = 0; i < 32; i++)
            rf[i] = '0;
        exp8 = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21};
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.len   = 6'd8;
        bus.f0    = 8'd1;
        bus.f1    = 8'd1;
        tick();
        tick();
        chk("reset_outputs",
            {bus.ra1, bus.ra2, bus.wa, bus.we, bus.wd_sel,
             bus.init_data, bus.busy, bus.done, bus.ovf}, 0);
        chk("reset_no_write", total_w, 0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();

        run(6'd8, 8'd1, 8'd1, 1'b0, dc, bc, nw);
        chk("basic_done_cycle", dc, 15);
        chk("basic_busy_cycles", bc, 14);
        chk("basic_writes", nw, 8);
        chk("basic_ovf", bus.ovf, 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("basic_entry%0d", i), rf[i], exp8[i]);

        run(6'd0, 8'd7, 8'd9, 1'b0, dc, bc, nw);
        chk("len0_done_cycle", dc, 3);
        chk("len0_writes", nw, 2);
        chk("len0_entry0", rf[0], 7);
        chk("len0_entry1", rf[1], 9);
        chk("len0_entry2_kept", rf[2], 2);

        run(6'd40, 8'd0, 8'd1, 1'b0, dc, bc, nw);
        chk("len40_done_cycle", dc, 63);
        chk("len40_writes", nw, 32);
        chk("len40_last_wa", last_wa, 31);
        chk("len40_entry10", rf[10], 55);

        run(6'd13, 8'd1, 8'd1, 1'b0, dc, bc, nw);
        chk("len13_ovf", bus.ovf, 0);
        chk("len13_entry12", rf[12], 233);

        run(6'd14, 8'd1, 8'd1, 1'b0, dc, bc, nw);
        chk("len14_done_cycle", dc, 27);
        chk("len14_ovf_at_done", bus.ovf, 1);
        chk("len14_entry13", rf[13], 121);
        tick();
        tick();
        chk("ovf_sticky_idle", bus.ovf, 1);
        bus.len   = 6'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ovf_cleared_s0", bus.ovf, 0);
        chk("s0_we", bus.we, 1);
        tick();
        tick();
        chk("len2_done", bus.done, 1);

        run(6'd8, 8'd1, 8'd1, 1'b1, dc, bc, nw);
        chk("busy_start_done_cycle", dc, 15);
        chk("busy_start_writes", nw, 8);
        chk("busy_start_last_wa", last_wa, 7);

        tick();
        bus.len   = 6'd8;
        bus.f0    = 8'd2;
        bus.f1    = 8'd2;
        bus.start = 1'b1;
        w0        = total_w;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 7; c++)
            tick();
        chk("midrst_rd_k4", {bus.we, bus.wd_sel, bus.wa}, {2'b01, 5'd4});
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_writes", total_w - w0, 4);
        rst_n = 1'b1;
        nw    = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done || bus.we)
                nw++;
            tick();
        end
        chk("midrst_quiet", nw, 0);
        chk("midrst_entry4_kept", rf[4], 5);

        run(6'd5, 8'd1, 8'd1, 1'b0, dc, bc, nw);
        chk("after_rst_done_cycle", dc, 9);
        chk("after_rst_writes", nw, 5);
        chk("after_rst_entry4", rf[4], 5);
        chk("after_rst_entry3", rf[3], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Sequencer that drives a register-file + adder datapath to fill consecutive register entries with a Fibonacci-style series.
- Seeds entries 0 and 1 from two input values. Then, for each k from 2 to len-1, reads entries k-2 and k-1 and writes their sum to entry k.
- Sits between a top-level start/done interface and the register file's two read ports and one write port.
- Replaces free-running sequencing with an explicit start/busy/done handshake, a programmable length and a sticky overflow flag.

Parameters:
ADDR_W, 5, register-file address width; depth is 2^ADDR_W entries
DATA_W, 8, register data width; width of seed values and of the adder

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request a run; sampled only in IDLE
len  input  ADDR_W+1  number of entries to produce; clamped to the range 2..2^ADDR_W
f0  input  DATA_W  seed value written to entry 0
f1  input  DATA_W  seed value written to entry 1
alu_cout  input  1  carry-out of the external adder (rd1+rd2), sampled in WR
ra1  output  ADDR_W  read address 1 (k-2)
ra2  output  ADDR_W  read address 2 (k-1)
wa  output  ADDR_W  write address
we  output  1  register-file write enable
wd_sel  output  1  write-data mux select: 0 = init_data, 1 = adder sum
init_data  output  DATA_W  seed value presented during seed writes
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse at end of run
ovf  output  1  sticky: a carry occurred on any sum written in this run

Behaviour:
- Reset: when rst_n=0 at a clock edge, state becomes IDLE. All outputs go to 0, k=0 and the latched length is 0. Reset asserted mid-run aborts the run on that edge; no further writes occur and done is not pulsed.
- Start acceptance: in IDLE, start=1 latches clamp(len), f0 and f1, and clears ovf. The next state is S0.
- Start in any state other than IDLE is ignored.
- States and transitions:
  - IDLE: busy=0, we=0.
  - S0: wa=0, init_data=f0, wd_sel=0, we=1. Next state S1.
  - S1: wa=1, init_data=f1, wd_sel=0, we=1. Set k=2. If the latched length is 2, next state DONE; else next state RD.
  - RD: ra1=k-2, ra2=k-1, wa=k, wd_sel=1, we=0. This cycle lets the combinational read and the adder settle. Next state WR.
  - WR: same addresses as RD, with we=1. If alu_cout=1, set ovf. If k = length-1, next state DONE; else k=k+1 and next state RD.
  - DONE: done=1 and busy=0 for exactly one cycle. Next state IDLE. ovf holds its value until the next accepted start.
- busy is 1 in S0, S1, RD and WR.
- Addresses and init_data are don't-care when we=0 outside RD; drive them to 0 in IDLE and DONE.
- Arithmetic: k is ADDR_W+1 bits wide so that length 2^ADDR_W terminates correctly. Address outputs are the low ADDR_W bits of the address expressions.
- Latency: the run takes 3 + 2*(L-2) cycles from the first cycle after start is accepted through DONE inclusive, where L is the clamped length. There are exactly L write cycles.
- Clamping: len=0 or 1 is treated as 2. len > 2^ADDR_W is treated as 2^ADDR_W.
- Simultaneous rst_n=0 and start=1: reset wins.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> state IDLE, all outputs 0, no we pulse.
- Basic run: f0=1, f1=1, len=8, start for 1 cycle.
  - Writes occur in order: entry0=1, entry1=1, then entry2..7 = 2, 3, 5, 8, 13, 21.
  - done pulses in the 15th cycle after acceptance; ovf=0.
  - busy is high for 14 cycles.
- Minimum and clamping:
  - len=0 -> exactly 2 writes (entries 0 and 1), done in the 3rd cycle.
  - len=40 with ADDR_W=5 -> 32 writes, last write to entry 31, done in the 63rd cycle.
- Overflow, DATA_W=8, f0=f1=1:
  - len=13 -> ovf=0 (last value 233).
  - len=14 -> ovf=1 after entry 13; ovf stays 1 after done until the next start, and is cleared in the cycle after that start is accepted.
- Start while busy: pulse start with len=3 during the WR of a len=8 run -> ignored, run completes with 8 writes.
- Reset mid-run: assert rst_n=0 during the RD for k=4 -> no write to entry 4, done never pulses, next start runs normally.
